// File: rtl/emu_time_sched_if.sv
// Scheduler bus for emu_time_sched: clock times in, run/stop/step controls, broadcast time out.
// Optional TIME_LIMIT_EN adds the time_limit field.
interface emu_time_sched_if #(
  parameter int N_CLK      = 2,
  parameter int TIME_WIDTH = 32,
  parameter int STEP_WIDTH = 16
);
  // Handshake: run_req/stop_req/step_req are single-cycle pulses with no ready; they are acted on
  // (or dropped) at the edge that samples them. issue is a valid-only strobe qualifying time_next
  // for exactly one cycle; there is no backpressure, every emulated clock must consume it then.
  logic [N_CLK*TIME_WIDTH-1:0] time_in;
  logic                        run_req;
  logic                        stop_req;
  logic                        step_req;
  logic [STEP_WIDTH-1:0]       step_count;
`ifdef TIME_LIMIT_EN
  logic [TIME_WIDTH-1:0]       time_limit;
`endif
  logic [TIME_WIDTH-1:0]       time_next;
  logic                        issue;
  logic                        busy;
  logic                        done;
  logic [STEP_WIDTH-1:0]       steps_left;
  logic [31:0]                 event_cnt;

  modport master (
    output time_in, run_req, stop_req, step_req, step_count,
`ifdef TIME_LIMIT_EN
    output time_limit,
`endif
    input  time_next, issue, busy, done, steps_left, event_cnt
  );

  modport slave (
    input  time_in, run_req, stop_req, step_req, step_count,
`ifdef TIME_LIMIT_EN
    input  time_limit,
`endif
    output time_next, issue, busy, done, steps_left, event_cnt
  );
endinterface

// File: rtl/emu_time_sched.sv
// Central time scheduler: broadcasts min(time_in) as time_next under a run/stop/step controller.
// Define TIME_LIMIT_EN to add the time_limit halt and the LIMIT state.
module emu_time_sched #(
  parameter int N_CLK      = 2,
  parameter int TIME_WIDTH = 32,
  parameter int STEP_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  emu_time_sched_if.slave      bus,
  output logic [1:0]           dbg_state_o
);

  localparam logic [TIME_WIDTH-1:0] SENTINEL = {TIME_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2
`ifdef TIME_LIMIT_EN
    ,
    S_LIMIT = 2'd3
`endif
  } state_e;

  state_e                state_q, state_d;
  logic                  phase_q, phase_d;
  logic [TIME_WIDTH-1:0] time_next_q, time_next_d;
  logic                  issue_q, issue_d;
  logic                  done_q, done_d;
  logic [STEP_WIDTH-1:0] steps_left_q, steps_left_d;
  logic [31:0]           event_cnt_q, event_cnt_d;
  logic [TIME_WIDTH-1:0] min_val;

  always_comb begin
    min_val = bus.time_in[TIME_WIDTH-1:0];
    for (int i = 1; i < N_CLK; i++) begin
      if (bus.time_in[i*TIME_WIDTH +: TIME_WIDTH] < min_val)
        min_val = bus.time_in[i*TIME_WIDTH +: TIME_WIDTH];
    end
  end

  // phase defaults to 0 so every entry into RUN/STEP starts on an ISSUE cycle.
  always_comb begin
    state_d      = state_q;
    phase_d      = 1'b0;
    time_next_d  = SENTINEL;
    issue_d      = 1'b0;
    done_d       = 1'b0;
    steps_left_d = steps_left_q;
    event_cnt_d  = event_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.stop_req) begin
          if (bus.run_req) begin
            state_d = S_RUN;
          end else if (bus.step_req) begin
            if (bus.step_count != '0) begin
              state_d      = S_STEP;
              steps_left_d = bus.step_count;
            end else begin
              done_d = 1'b1;
            end
          end
        end
      end
      S_RUN, S_STEP: begin
        if (bus.stop_req) begin
          state_d      = S_IDLE;
          steps_left_d = '0;
        end else if (!phase_q) begin
          phase_d = 1'b1;
`ifdef TIME_LIMIT_EN
          if (min_val >= bus.time_limit) begin
            state_d      = S_LIMIT;
            phase_d      = 1'b0;
            done_d       = 1'b1;
            steps_left_d = '0;
          end else
`endif
          begin
            time_next_d = min_val;
            issue_d     = 1'b1;
            event_cnt_d = event_cnt_q + 32'd1;
            if (state_q == S_STEP)
              steps_left_d = steps_left_q - STEP_WIDTH'(1);
          end
        end else if (state_q == S_STEP && steps_left_q == '0) begin
          // Last event has had its SETTLE cycle; finish now.
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
`ifdef TIME_LIMIT_EN
      S_LIMIT: begin
        if (bus.stop_req)
          state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      time_next_q  <= SENTINEL;
      issue_q      <= 1'b0;
      done_q       <= 1'b0;
      steps_left_q <= '0;
      event_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      time_next_q  <= time_next_d;
      issue_q      <= issue_d;
      done_q       <= done_d;
      steps_left_q <= steps_left_d;
      event_cnt_q  <= event_cnt_d;
    end
  end

  assign bus.time_next  = time_next_q;
  assign bus.issue      = issue_q;
  assign bus.done       = done_q;
  assign bus.steps_left = steps_left_q;
  assign bus.event_cnt  = event_cnt_q;
  assign bus.busy       = (state_q == S_RUN) || (state_q == S_STEP);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_emu_time_sched.sv
// Bench for emu_time_sched: two emulated clocks (inc 3 and 5) consume time_next; issued times are
// scoreboarded against a software copy of those clocks.
module tb_emu_time_sched;

  localparam logic [15:0] SENT = 16'hFFFF;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  emu_time_sched_if #(.N_CLK(2), .TIME_WIDTH(16), .STEP_WIDTH(16)) bus ();

  emu_time_sched #(.N_CLK(2), .TIME_WIDTH(16), .STEP_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // emulated clock instances: advance when the broadcast time equals their own time
  logic [15:0] tc0 = 16'd0;
  logic [15:0] tc1 = 16'd0;
  always @(posedge clk) begin
    if (bus.issue && bus.time_next == tc0) tc0 <= tc0 + 16'd3;
    if (bus.issue && bus.time_next == tc1) tc1 <= tc1 + 16'd5;
  end
  assign bus.time_in = {tc1, tc0};

  // scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_cnt  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m0 = 16'd0;
  logic [15:0] m1 = 16'd0;
  logic        prev_issue = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_events(input int n);
    logic [15:0] mn;
    for (int i = 0; i < n; i++) begin
      mn = (m0 < m1) ? m0 : m1;
      exp_q.push_back(mn);
      if (m0 == mn) m0 = m0 + 16'd3;
      if (m1 == mn) m1 = m1 + 16'd5;
    end
    exp_cnt += n;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.issue) begin
        if (prev_issue) check("issue_back_to_back", 32'd1, 32'd0);
        if (exp_q.size() == 0) check("issue_unexpected", 32'd1, 32'd0);
        else check("time_next", 32'(bus.time_next), 32'(exp_q.pop_front()));
      end else begin
        check("idle_sentinel", 32'(bus.time_next), 32'(SENT));
      end
      prev_issue <= bus.issue;
    end else begin
      prev_issue <= 1'b0;
    end
  end

  // driver tasks (called at posedge+1, return at posedge+1)
  task automatic pulse(input logic r, input logic s, input logic t, input logic [15:0] cnt);
    bus.run_req    = r;
    bus.stop_req   = s;
    bus.step_req   = t;
    bus.step_count = cnt;
    @(posedge clk); #1;
    bus.run_req    = 1'b0;
    bus.stop_req   = 1'b0;
    bus.step_req   = 1'b0;
    bus.step_count = $urandom_range(0, 65535);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (bus.done !== 1'b1 && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    check(tag, 32'(bus.done), 32'd1);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.run_req    = 1'b0;
    bus.stop_req   = 1'b0;
    bus.step_req   = 1'b0;
    bus.step_count = 16'd0;
`ifdef TIME_LIMIT_EN
    bus.time_limit = SENT;
`endif
    cycles(3);
    rst_n = 1'b1;

    // reset state, no requests
    cycles(20);
    check("rst_time_next", 32'(bus.time_next), 32'(SENT));
    check("rst_issue", 32'(bus.issue), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_steps_left", 32'(bus.steps_left), 32'd0);
    check("rst_event_cnt", bus.event_cnt, 32'd0);

`ifdef TIME_LIMIT_EN
    // limit: run from time 0 with limit 10 issues 0,3,5,6,9 then halts
    bus.time_limit = 16'd10;
    push_events(5);
    pulse(1'b1, 1'b0, 1'b0, 16'd0);
    check("lim_busy_run", 32'(bus.busy), 32'd1);
    wait_done("lim_done", 30);
    check("lim_busy", 32'(bus.busy), 32'd0);
    check("lim_steps_left", 32'(bus.steps_left), 32'd0);
    check("lim_event_cnt", bus.event_cnt, 32'(exp_cnt));
    cycles(1);
    check("lim_done_pulse", 32'(bus.done), 32'd0);
    pulse(1'b1, 1'b0, 1'b0, 16'd0);
    cycles(4);
    check("lim_run_ignored", 32'(bus.busy), 32'd0);
    pulse(1'b0, 1'b1, 1'b0, 16'd0);
    pulse(1'b1, 1'b0, 1'b0, 16'd0);
    check("lim_idle_then_run", 32'(bus.busy), 32'd1);
    pulse(1'b0, 1'b1, 1'b0, 16'd0);
    check("lim_stop_busy", 32'(bus.busy), 32'd0);
    bus.time_limit = SENT;
`endif

    // step of 4: issues on alternate cycles, done after the 8th cycle
    push_events(4);
    pulse(1'b0, 1'b0, 1'b1, 16'd4);
    check("step_busy", 32'(bus.busy), 32'd1);
    check("step_left_init", 32'(bus.steps_left), 32'd4);
    cycles(7);
    check("step_last_issue", 32'(bus.issue), 32'd1);
    check("step_left_zero", 32'(bus.steps_left), 32'd0);
    check("step_no_early_done", 32'(bus.done), 32'd0);
    cycles(1);
    check("step_done", 32'(bus.done), 32'd1);
    check("step_idle", 32'(bus.busy), 32'd0);
    check("step_event_cnt", bus.event_cnt, 32'(exp_cnt));
    cycles(1);
    check("step_done_pulse", 32'(bus.done), 32'd0);

    // run, ignored step_req, stop sampled 8 edges after run: 4 issues
    push_events(4);
    pulse(1'b1, 1'b0, 1'b0, 16'd0);
    cycles(1);
    pulse(1'b0, 1'b0, 1'b1, 16'd3);
    check("run_step_ignored", 32'(bus.steps_left), 32'd0);
    cycles(5);
    pulse(1'b0, 1'b1, 1'b0, 16'd0);
    check("stop_sentinel", 32'(bus.time_next), 32'(SENT));
    check("stop_issue", 32'(bus.issue), 32'd0);
    check("stop_busy", 32'(bus.busy), 32'd0);
    check("stop_event_cnt", bus.event_cnt, 32'(exp_cnt));

    // run + stop together stays idle
    pulse(1'b1, 1'b1, 1'b0, 16'd0);
    check("runstop_busy", 32'(bus.busy), 32'd0);
    cycles(4);
    check("runstop_event_cnt", bus.event_cnt, 32'(exp_cnt));

    // step with count 0: done pulse, no issue
    pulse(1'b0, 1'b0, 1'b1, 16'd0);
    check("step0_done", 32'(bus.done), 32'd1);
    check("step0_busy", 32'(bus.busy), 32'd0);
    cycles(1);
    check("step0_done_pulse", 32'(bus.done), 32'd0);

    // stop mid-step: one issue, then abort without done
    push_events(1);
    pulse(1'b0, 1'b0, 1'b1, 16'd3);
    cycles(1);
    pulse(1'b0, 1'b1, 1'b0, 16'd0);
    check("abort_steps_left", 32'(bus.steps_left), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_no_done", 32'(bus.done), 32'd0);
    check("abort_event_cnt", bus.event_cnt, 32'(exp_cnt));

    // async reset mid-step with steps_left=2
    push_events(2);
    pulse(1'b0, 1'b0, 1'b1, 16'd4);
    cycles(4);
    check("mid_steps_left", 32'(bus.steps_left), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_time_next", 32'(bus.time_next), 32'(SENT));
    check("mid_rst_issue", 32'(bus.issue), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_steps_left", 32'(bus.steps_left), 32'd0);
    check("mid_rst_event_cnt", bus.event_cnt, 32'd0);
    exp_cnt = 0;
    cycles(5);
    rst_n = 1'b1;
    cycles(10);
    check("hold_clk0", 32'(tc0), 32'(m0));
    check("hold_clk1", 32'(tc1), 32'(m1));
    check("hold_event_cnt", bus.event_cnt, 32'd0);

    // single step after reset
    push_events(1);
    pulse(1'b0, 1'b0, 1'b1, 16'd1);
    cycles(2);
    check("post_step_done", 32'(bus.done), 32'd1);
    check("post_event_cnt", bus.event_cnt, 32'(exp_cnt));

    cycles(3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
